uart_tx: RTL and testbench

UART transmitter serializing one byte per request onto o_TX_Serial. Frame is start bit, 8 data bits LSB first, optional parity bit, then 1 or 2 stop bits. It is the transmit counterpart of UART_Rx and shares its bit timing: CLKS_PER_BIT = 217 gives 115200 baud at 25 MHz. It sits between command or response logic and the board TX pin.

---
 rtl/uart_tx.sv | 128 ++++++++++++
 tb/tb_uart_tx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
// Every output is a flop; its next value comes from the next-state values, so nothing on the
// input side reaches a pin in the same cycle.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Ready,
  output logic       o_TX_Active,
  output logic       o_TX_Serial,
  output logic       o_TX_Done
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] StopLast = 3'(STOP_BITS - 1);
  localparam logic ParityOdd = (PARITY_ODD != 0);
  localparam logic ParityEn = (PARITY_EN != 0);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  // Data bit index in StData, stop bit index in StStop.
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      data_q, data_d;
  logic            serial_d, ready_d, active_d, done_d;
  logic            bit_end;

  // Next-state logic and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    bit_end = (cnt_q == CntLast);

    if (state_q != StIdle) begin
      cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
    end

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        idx_d = '0;
        // Ready is high exactly in StIdle, so a request here is an accept.
        if (i_TX_DV) begin
          data_d  = i_TX_Byte;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          idx_d   = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
            state_d = ParityEn ? StParity : StStop;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          idx_d   = '0;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (idx_q == StopLast) begin
            state_d = StIdle;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    serial_d = 1'b1;
    case (state_d)
      StStart:  serial_d = 1'b0;
      StData:   serial_d = data_d[idx_d];
      StParity: serial_d = (^data_d) ^ ParityOdd;
      default:  serial_d = 1'b1;
    endcase
    ready_d  = (state_d == StIdle);
    active_d = (state_d != StIdle);
    done_d   = (state_d == StStop) && (cnt_d == CntLast) && (idx_d == StopLast);
  end

  // State, counters, held byte and output registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      o_TX_Serial <= 1'b1;
      o_TX_Ready  <= 1'b1;
      o_TX_Active <= 1'b0;
      o_TX_Done   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      o_TX_Serial <= serial_d;
      o_TX_Ready  <= ready_d;
      o_TX_Active <= active_d;
      o_TX_Done   <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: four instances (default timing, fast plain, fast even and
// odd parity with two stop bits) driven by a frame table plus hand-written corner sequences.
module tb_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rst1;
  logic       dv0, dv1, dv2;
  logic [7:0] b0, b1, b2;
  logic       rdy0, act0, ser0, done0;
  logic       rdy1, act1, ser1, done1;
  logic       rdy2, act2, ser2, done2;
  logic       rdy3, act3, ser3, done3;

  uart_tx u_d0 (
    .clk(clk), .rst(rst), .i_TX_DV(dv0), .i_TX_Byte(b0),
    .o_TX_Ready(rdy0), .o_TX_Active(act0), .o_TX_Serial(ser0), .o_TX_Done(done0)
  );
  uart_tx #(.CLKS_PER_BIT(4)) u_d1 (
    .clk(clk), .rst(rst1), .i_TX_DV(dv1), .i_TX_Byte(b1),
    .o_TX_Ready(rdy1), .o_TX_Active(act1), .o_TX_Serial(ser1), .o_TX_Done(done1)
  );
  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_d2 (
    .clk(clk), .rst(rst), .i_TX_DV(dv2), .i_TX_Byte(b2),
    .o_TX_Ready(rdy2), .o_TX_Active(act2), .o_TX_Serial(ser2), .o_TX_Done(done2)
  );
  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_d3 (
    .clk(clk), .rst(rst), .i_TX_DV(dv2), .i_TX_Byte(b2),
    .o_TX_Ready(rdy3), .o_TX_Active(act3), .o_TX_Serial(ser3), .o_TX_Done(done3)
  );

  int   cur_sel = 0;
  logic s_rdy, s_act, s_ser, s_done;

  always_comb begin
    s_rdy = rdy0; s_act = act0; s_ser = ser0; s_done = done0;
    case (cur_sel)
      1: begin s_rdy = rdy1; s_act = act1; s_ser = ser1; s_done = done1; end
      2: begin s_rdy = rdy2; s_act = act2; s_ser = ser2; s_done = done2; end
      3: begin s_rdy = rdy3; s_act = act3; s_ser = ser3; s_done = done3; end
      default: ;
    endcase
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [7:0] b);
    case (sel)
      0:       begin dv0 = v; b0 = b; end
      1:       begin dv1 = v; b1 = b; end
      default: begin dv2 = v; b2 = b; end
    endcase
  endtask

  function automatic int clks(input int sel);
    return (sel == 0) ? 217 : 4;
  endfunction

  // One frame: accept, check line at each bit centre, Done timing, Active length, idle tail.
  // poke >= 0 pulses a 0xFF request in that cycle of the frame, which must be ignored.
  task automatic run_frame(input int sel, input logic [7:0] data, input string bits,
                           input int poke, input string name);
    int c, total, wait_n, act_cnt, done_cnt;
    c = clks(sel);
    total = bits.len() * c;
    wait_n = 0; act_cnt = 0; done_cnt = 0;
    cur_sel = sel;
    @(negedge clk);
    while (!s_rdy && wait_n < 5000) begin
      @(negedge clk);
      wait_n++;
    end
    check({name, "_ready"}, int'(s_rdy), 1);
    drive(sel, 1'b1, data);
    @(negedge clk);
    drive(sel, 1'b0, ~data);
    for (int t = 0; t < total + 2 * c; t++) begin
      if (t < total && (t % c) == c / 2)
        check($sformatf("%s_bit%0d", name, t / c), int'(s_ser), int'(bits[t / c] == "1"));
      if (s_act) act_cnt++;
      if (s_done) begin
        done_cnt++;
        check({name, "_done_time"}, t, total - 1);
        check({name, "_done_ready"}, int'(s_rdy), 0);
      end
      if (t == 0) check({name, "_start_active"}, int'(s_act), 1);
      if (t == total) begin
        check({name, "_idle_ser"}, int'(s_ser), 1);
        check({name, "_idle_rdy"}, int'(s_rdy), 1);
        check({name, "_idle_act"}, int'(s_act), 0);
      end
      if (t == total + 2 * c - 1) check({name, "_tail_ser"}, int'(s_ser), 1);
      if (t == poke) drive(sel, 1'b1, 8'hFF);
      else drive(sel, 1'b0, ~data);
      @(negedge clk);
    end
    check({name, "_active_len"}, act_cnt, total);
    check({name, "_done_count"}, done_cnt, 1);
  endtask

  typedef struct {
    int         sel;
    logic [7:0] data;
    string      bits;
    int         poke;
    string      name;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   dcnt;

    vecs[0] = '{sel: 0, data: 8'h37, bits: "0111011001",   poke: -1, name: "d0_37"};
    vecs[1] = '{sel: 0, data: 8'hA5, bits: "0101001011",   poke: -1, name: "d0_a5"};
    vecs[2] = '{sel: 1, data: 8'h00, bits: "0000000001",   poke: 13, name: "busy_00"};
    vecs[3] = '{sel: 1, data: 8'hFF, bits: "0111111111",   poke: -1, name: "d1_ff"};
    vecs[4] = '{sel: 2, data: 8'h37, bits: "011101100111", poke: -1, name: "even_37"};
    vecs[5] = '{sel: 3, data: 8'h37, bits: "011101100011", poke: -1, name: "odd_37"};

    rst = 1'b1; rst1 = 1'b1;
    dv0 = 1'b0; dv1 = 1'b0; dv2 = 1'b0;
    b0 = 8'h00; b1 = 8'h00; b2 = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0; rst1 = 1'b0;

    for (int s = 0; s < 4; s++) begin
      cur_sel = s;
      #1;
      check($sformatf("reset_ser%0d", s), int'(s_ser), 1);
      check($sformatf("reset_rdy%0d", s), int'(s_rdy), 1);
      check($sformatf("reset_act%0d", s), int'(s_act), 0);
      check($sformatf("reset_done%0d", s), int'(s_done), 0);
    end

    for (int i = 0; i < 6; i++)
      run_frame(vecs[i].sel, vecs[i].data, vecs[i].bits, vecs[i].poke, vecs[i].name);

    // Back-to-back with the request held high: 0x00 then 0xFF, one idle cycle between.
    cur_sel = 1;
    dcnt = 0;
    @(negedge clk);
    drive(1, 1'b1, 8'h00);
    @(negedge clk);
    drive(1, 1'b1, 8'hFF);
    for (int t = 0; t < 90; t++) begin
      if (t < 40 && (t % 4) == 2)
        check($sformatf("b2b_a_bit%0d", t / 4), int'(s_ser), int'(t / 4 == 9));
      if (t >= 41 && t < 81 && ((t - 41) % 4) == 2)
        check($sformatf("b2b_b_bit%0d", (t - 41) / 4), int'(s_ser), int'((t - 41) / 4 != 0));
      if (s_done) begin
        dcnt++;
        check("b2b_done_time", int'(t == 39 || t == 80), 1);
      end
      if (t == 40) begin
        check("b2b_gap_ser", int'(s_ser), 1);
        check("b2b_gap_rdy", int'(s_rdy), 1);
      end
      if (t == 41) begin
        check("b2b_start_ser", int'(s_ser), 0);
        check("b2b_start_act", int'(s_act), 1);
        drive(1, 1'b0, 8'h00);
      end
      if (t == 88) check("b2b_tail_ser", int'(s_ser), 1);
      @(negedge clk);
    end
    check("b2b_done_count", dcnt, 2);

    // Reset for one cycle during data bit 3 of an 0xFF frame, then a clean 0x5A frame.
    dcnt = 0;
    drive(1, 1'b1, 8'hFF);
    @(negedge clk);
    drive(1, 1'b0, 8'h00);
    for (int t = 0; t < 40; t++) begin
      if (t == 16) check("rst_pre_ser", int'(s_ser), 1);
      if (t >= 18 && s_done) dcnt++;
      if (t == 18) begin
        check("rst_ser", int'(s_ser), 1);
        check("rst_act", int'(s_act), 0);
        check("rst_rdy", int'(s_rdy), 1);
        check("rst_done", int'(s_done), 0);
      end
      if (t == 30) check("rst_idle_ser", int'(s_ser), 1);
      rst1 = (t == 17);
      @(negedge clk);
    end
    check("rst_no_done", dcnt, 0);
    run_frame(1, 8'h5A, "0010110101", -1, "rst_5a");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
